// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative cache: controller states,
// default geometry and a constant-foldable log2 helper.
package cache_pkg;

    localparam int unsigned DEF_SETS = 256;
    localparam int unsigned DEF_WAYS = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COMPARE   = 2'd1,
        ST_WRITEBACK = 2'd2,
        ST_ALLOCATE  = 2'd3
    } state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cache_lru.sv
// Age-based LRU update for one set: the accessed way becomes youngest and
// every way younger than it ages by one, keeping the ages a permutation.
module cache_lru
    import cache_pkg::*;
#(
    parameter int unsigned WAYS = DEF_WAYS,
    parameter int unsigned AW   = clog2(DEF_WAYS)
) (
    input  logic [WAYS-1:0][AW-1:0] ages_i,
    input  logic [AW-1:0]           acc_way_i,
    output logic [WAYS-1:0][AW-1:0] ages_o,
    output logic [AW-1:0]           lru_way_o
);

    logic [AW-1:0] acc_age;

    assign acc_age = ages_i[acc_way_i];

    always_comb begin
        ages_o    = ages_i;
        lru_way_o = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (AW'(w) == acc_way_i) begin
                ages_o[w] = '0;
            end else if (ages_i[w] < acc_age) begin
                ages_o[w] = ages_i[w] + AW'(1);
            end
            if (ages_i[w] == AW'(WAYS - 1)) lru_way_o = AW'(w);
        end
    end

endmodule

// File: rtl/set_assoc_cache.sv
// Write-back, write-allocate set-associative cache with one-word lines,
// age-based LRU replacement and saturating hit/miss/writeback counters.
module set_assoc_cache
    import cache_pkg::*;
#(
    parameter int unsigned SETS  = DEF_SETS,
    parameter int unsigned WAYS  = DEF_WAYS,
    parameter int unsigned CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [31:0]      cpu_req_addr,
    input  logic             cpu_req_valid,
    input  logic             cpu_req_rw,
    input  logic [31:0]      cpu_data_write,
    output logic [31:0]      cpu_data_read,
    output logic             cpu_ready,
    output logic             cpu_idle,
    output logic [31:0]      mem_req_addr,
    output logic             mem_req_rw,
    output logic             mem_req_valid,
    output logic [31:0]      mem_data_write,
    input  logic [31:0]      mem_data_read,
    input  logic             mem_ready,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] wb_count
);

    localparam int unsigned IW = clog2(SETS);
    localparam int unsigned AW = clog2(WAYS);
    localparam int unsigned TW = 30 - IW;

    typedef logic [WAYS-1:0][AW-1:0] ages_t;

    function automatic ages_t age_row();
        ages_t r;
        for (int w = 0; w < WAYS; w++) r[w] = AW'(w);
        return r;
    endfunction

    localparam ages_t AGE_ROW = age_row();

    state_e                    state_q;
    logic [29:0]               line_q;
    logic                      rw_q;
    logic [31:0]               wdata_q;
    logic [AW-1:0]             victim_q;
    logic                      refill_q;
    logic [SETS-1:0][WAYS-1:0] valid_q;
    logic [SETS-1:0][WAYS-1:0] dirty_q;
    logic [SETS-1:0]           [WAYS-1:0][AW-1:0] age_q;
    logic [TW-1:0]             tag_q  [SETS][WAYS];
    logic [31:0]               data_q [SETS][WAYS];

    logic                      cpu_ready_q;
    logic [31:0]               cpu_data_read_q;
    logic                      mem_req_valid_q;
    logic                      mem_req_rw_q;
    logic [31:0]               mem_req_addr_q;
    logic [31:0]               mem_data_write_q;
    logic [CNT_W-1:0]          hit_count_q;
    logic [CNT_W-1:0]          miss_count_q;
    logic [CNT_W-1:0]          wb_count_q;

    logic [IW-1:0]             idx_c;
    logic [TW-1:0]             tag_c;
    logic                      hit_c;
    logic [AW-1:0]             hit_way_c;
    logic [AW-1:0]             victim_c;
    logic [AW-1:0]             lru_way_c;
    ages_t                     lru_ages_c;
    logic                      unused_addr_lsb;

    assign unused_addr_lsb = ^cpu_req_addr[1:0];

    assign idx_c = line_q[IW-1:0];
    assign tag_c = line_q[29:IW];

    always_comb begin
        hit_c     = 1'b0;
        hit_way_c = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit_c && valid_q[idx_c][w] && (tag_q[idx_c][w] == tag_c)) begin
                hit_c     = 1'b1;
                hit_way_c = AW'(w);
            end
        end
    end

    // Prefer the lowest-numbered empty way; only evict once the set is full.
    always_comb begin
        logic found;
        found    = 1'b0;
        victim_c = lru_way_c;
        for (int w = 0; w < WAYS; w++) begin
            if (!found && !valid_q[idx_c][w]) begin
                found    = 1'b1;
                victim_c = AW'(w);
            end
        end
    end

    cache_lru #(
        .WAYS (WAYS),
        .AW   (AW)
    ) u_lru (
        .ages_i    (age_q[idx_c]),
        .acc_way_i (hit_way_c),
        .ages_o    (lru_ages_c),
        .lru_way_o (lru_way_c)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q          <= ST_IDLE;
            line_q           <= '0;
            rw_q             <= 1'b0;
            wdata_q          <= '0;
            victim_q         <= '0;
            refill_q         <= 1'b0;
            valid_q          <= '0;
            dirty_q          <= '0;
            age_q            <= {SETS{AGE_ROW}};
            cpu_ready_q      <= 1'b0;
            cpu_data_read_q  <= '0;
            mem_req_valid_q  <= 1'b0;
            mem_req_rw_q     <= 1'b0;
            mem_req_addr_q   <= '0;
            mem_data_write_q <= '0;
            hit_count_q      <= '0;
            miss_count_q     <= '0;
            wb_count_q       <= '0;
        end else begin
            cpu_ready_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cpu_req_valid) begin
                        line_q  <= cpu_req_addr[31:2];
                        rw_q    <= cpu_req_rw;
                        wdata_q <= cpu_data_write;
                        state_q <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    if (hit_c) begin
                        state_q      <= ST_IDLE;
                        cpu_ready_q  <= 1'b1;
                        refill_q     <= 1'b0;
                        age_q[idx_c] <= lru_ages_c;
                        // The re-compare after a fill was already counted as a miss.
                        if (!refill_q && (hit_count_q != '1)) hit_count_q <= hit_count_q + CNT_W'(1);
                        if (rw_q) dirty_q[idx_c][hit_way_c] <= 1'b1;
                        else      cpu_data_read_q <= data_q[idx_c][hit_way_c];
                    end else begin
                        victim_q        <= victim_c;
                        mem_req_valid_q <= 1'b1;
                        if (miss_count_q != '1) miss_count_q <= miss_count_q + CNT_W'(1);
                        if (valid_q[idx_c][victim_c] && dirty_q[idx_c][victim_c]) begin
                            mem_req_rw_q     <= 1'b1;
                            mem_req_addr_q   <= {tag_q[idx_c][victim_c], idx_c, 2'b00};
                            mem_data_write_q <= data_q[idx_c][victim_c];
                            state_q          <= ST_WRITEBACK;
                        end else begin
                            mem_req_rw_q   <= 1'b0;
                            mem_req_addr_q <= {line_q, 2'b00};
                            state_q        <= ST_ALLOCATE;
                        end
                    end
                end
                ST_WRITEBACK: begin
                    if (mem_ready) begin
                        if (wb_count_q != '1) wb_count_q <= wb_count_q + CNT_W'(1);
                        mem_req_rw_q   <= 1'b0;
                        mem_req_addr_q <= {line_q, 2'b00};
                        state_q        <= ST_ALLOCATE;
                    end
                end
                ST_ALLOCATE: begin
                    if (mem_ready) begin
                        valid_q[idx_c][victim_q] <= 1'b1;
                        dirty_q[idx_c][victim_q] <= 1'b0;
                        mem_req_valid_q          <= 1'b0;
                        refill_q                 <= 1'b1;
                        state_q                  <= ST_COMPARE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Tag/data storage carries no reset; valid bits qualify its contents.
    always_ff @(posedge CLK) begin
        if ((state_q == ST_COMPARE) && hit_c && rw_q) begin
            data_q[idx_c][hit_way_c] <= wdata_q;
        end
        if ((state_q == ST_ALLOCATE) && mem_ready) begin
            data_q[idx_c][victim_q] <= mem_data_read;
            tag_q[idx_c][victim_q]  <= tag_c;
        end
    end

    assign cpu_ready      = cpu_ready_q;
    assign cpu_data_read  = cpu_data_read_q;
    assign cpu_idle       = (state_q == ST_IDLE);
    assign mem_req_valid  = mem_req_valid_q;
    assign mem_req_rw     = mem_req_rw_q;
    assign mem_req_addr   = mem_req_addr_q;
    assign mem_data_write = mem_data_write_q;
    assign hit_count      = hit_count_q;
    assign miss_count     = miss_count_q;
    assign wb_count       = wb_count_q;

endmodule
